// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle CPU controller: FSM states, instruction classes, ALU opcodes.
// Also holds the default data and program-counter widths.
package cpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int PC_W_DEF   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [1:0] CLS_ALU   = 2'b00;
  localparam logic [1:0] CLS_LOADI = 2'b01;
  localparam logic [1:0] CLS_JMP   = 2'b10;
  localparam logic [1:0] CLS_HALT  = 2'b11;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

endpackage

// File: rtl/cpu_regfile.sv
// 4-entry register file: two asynchronous read ports, one synchronous write port.
// Zero read latency; write lands on the next rising edge; no backpressure.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [1:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle CPU controller (FETCH/DECODE/EXEC/WB); ALU and LOADI take 4 cycles, JMP 3, no backpressure.
// Optional macro CPU_CTRL_ZERO_FLAG_EN enables the zero flag and conditional jumps.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [1:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              halted,
  output logic              zero_flag
);

  state_t            state, state_nx;
  logic [PC_W-1:0]   pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [1:0]        cls;
  logic              we;
  logic              jmp_take;

  assign cls = ir[15:14];

  cpu_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (ir[11:10]),
    .wdata   (result),
    .raddr_a (ir[9:8]),
    .rdata_a (rd_a),
    .raddr_b (ir[7:6]),
    .rdata_b (rd_b)
  );

`ifdef CPU_CTRL_ZERO_FLAG_EN
  logic zf;

  always_ff @(posedge clk) begin
    if (rst) begin
      zf <= 1'b0;
    end else if (state == S_WB && cls == CLS_ALU) begin
      zf <= (result == '0);
    end
  end

  assign zero_flag = zf;
  assign jmp_take  = !ir[13] || zf;
`else
  assign zero_flag = 1'b0;
  assign jmp_take  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= '0;
      ir     <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE:   if (start) pc <= '0;
        S_DECODE: ir <= imem_rdata;
        S_EXEC: begin
          case (cls)
            CLS_ALU:   result <= alu_result;
            CLS_LOADI: result <= DATA_W'(ir[7:0]);
            CLS_JMP:   pc <= jmp_take ? PC_W'(ir[7:0]) : pc + PC_W'(1);
            default: ;
          endcase
        end
        S_WB:     pc <= pc + PC_W'(1);
        default: ;
      endcase
    end
  end

  // Operands come straight from the regfile, so rd==rs sees the pre-write value.
  always_comb begin
    state_nx = state;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = '0;
    we       = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        alu_a  = rd_a;
        alu_b  = rd_b;
        alu_op = ir[13:12];
        case (cls)
          CLS_JMP:  state_nx = S_FETCH;
          CLS_HALT: state_nx = S_HALT;
          default:  state_nx = S_WB;
        endcase
      end
      S_WB: begin
        we       = 1'b1;
        state_nx = S_FETCH;
      end
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign imem_addr = pc;
  assign wb_valid  = (state == S_WB);
  assign wb_rd     = (state == S_WB) ? ir[11:10] : 2'b00;
  assign wb_data   = (state == S_WB) ? result : '0;
  assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                     (state == S_EXEC)  || (state == S_WB);
  assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: small program images, cycle-exact writeback and jump checks.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic        wb_valid;
  logic [1:0]  wb_rd;
  logic [15:0] wb_data;
  logic        busy, halted, zero_flag;

  int n_total = 0;
  int n_pass  = 0;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  cpu_controller #(.DATA_W(16), .PC_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .busy       (busy),
    .halted     (halted),
    .zero_flag  (zero_flag)
  );

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  always_comb begin
    alu_result = alu_a + alu_b;
    case (alu_op_t'(alu_op))
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      default: alu_result = alu_a + alu_b;
    endcase
  end

  function automatic logic [15:0] f_alu(input logic [1:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
    return {2'b00, op, rd, rs1, rs2, 6'b0};
  endfunction

  function automatic logic [15:0] f_ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {2'b01, 2'b00, rd, 2'b00, imm};
  endfunction

  function automatic logic [15:0] f_jmp(input logic cond, input logic [7:0] tgt);
    return {2'b10, cond, 5'b0, tgt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Called while sampling FETCH; returns sampling the next FETCH.
  task automatic instr_wb(input string tag, input logic [1:0] rd, input logic [15:0] data);
    logic early;
    early = 1'b0;
    tick(); early |= wb_valid;
    tick(); early |= wb_valid;
    tick();
    chk({tag, ".early_wb"}, 32'(early), 32'd0);
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
    chk({tag, ".wb_data"}, 32'(wb_data), 32'(data));
    tick();
  endtask

  task automatic instr_op(input string tag, input logic [1:0] op, input logic [1:0] rd,
                          input logic [15:0] data);
    tick();
    chk({tag, ".op_decode"}, 32'(alu_op), 32'd0);
    tick();
    chk({tag, ".op_exec"}, 32'(alu_op), 32'(op));
    tick();
    chk({tag, ".op_wb"}, 32'(alu_op), 32'd0);
    chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
    chk({tag, ".wb_data"}, 32'(wb_data), 32'(data));
    tick();
  endtask

  task automatic jmp_chk(input string tag, input logic [7:0] nxt);
    logic seen;
    seen = 1'b0;
    tick(); seen |= wb_valid;
    tick(); seen |= wb_valid;
    tick();
    chk({tag, ".no_wb"}, 32'(seen), 32'd0);
    chk({tag, ".next_addr"}, 32'(imem_addr), 32'(nxt));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    logic [15:0] e;
    int a;
    rst   = 1'b1;
    start = 1'b0;
    clear_mem();
    tick();
    tick();
    chk("rst.imem_addr", 32'(imem_addr), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.wb_valid", 32'(wb_valid), 32'd0);
    chk("rst.alu", {alu_a, alu_b} | 32'(alu_op), 32'd0);
    chk("rst.zero_flag", 32'(zero_flag), 32'd0);

    // Program A: arithmetic, jump, wrap.
    mem[0] = f_ldi(2'd1, 8'd10);
    mem[1] = f_ldi(2'd2, 8'd5);
    mem[2] = f_alu(2'b00, 2'd3, 2'd1, 2'd2);
    mem[3] = f_alu(2'b01, 2'd0, 2'd2, 2'd1);
    mem[4] = f_alu(2'b11, 2'd3, 2'd1, 2'd2);
    mem[5] = f_jmp(1'b0, 8'h20);
    a = 32'h20;
    mem[a++] = f_ldi(2'd1, 8'hF0);
    for (int i = 0; i < 8; i++) mem[a++] = f_alu(2'b00, 2'd1, 2'd1, 2'd1);
    mem[a++] = f_ldi(2'd2, 8'hF0);
    mem[a++] = f_alu(2'b11, 2'd1, 2'd1, 2'd2);
    mem[a++] = f_ldi(2'd2, 8'hFF);
    for (int i = 0; i < 4; i++) mem[a++] = f_alu(2'b00, 2'd2, 2'd2, 2'd2);
    mem[a++] = f_alu(2'b10, 2'd3, 2'd1, 2'd2);
    mem[a++] = f_alu(2'b11, 2'd3, 2'd1, 2'd2);
    mem[a++] = f_alu(2'b00, 2'd3, 2'd3, 2'd1);
    mem[a++] = f_jmp(1'b0, 8'hFE);
    mem[8'hFE] = f_ldi(2'd0, 8'd7);
    mem[8'hFF] = f_ldi(2'd0, 8'd9);

    rst = 1'b0;
    tick();
    chk("idle.busy", 32'(busy), 32'd0);
    do_start();
    chk("fetch0.addr", 32'(imem_addr), 32'd0);
    chk("fetch0.busy", 32'(busy), 32'd1);
    instr_wb("ldi_r1", 2'd1, 16'd10);
    instr_wb("ldi_r2", 2'd2, 16'd5);
    instr_wb("add", 2'd3, 16'd15);
    instr_wb("sub", 2'd0, 16'hFFFB);
    chk("sub.zero_flag", 32'(zero_flag), 32'd0);
    instr_wb("or_small", 2'd3, 16'd15);
    chk("jmp.at_pc5", 32'(imem_addr), 32'd5);
    jmp_chk("jmp20", 8'h20);
    instr_wb("ldi_f0", 2'd1, 16'h00F0);
    e = 16'h00F0;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = e << 1;
      instr_wb("dbl_r1", 2'd1, e);
    end
    start = 1'b0;
    chk("start_ignored.addr", 32'(imem_addr), 32'h29);
    instr_wb("ldi_r2_f0", 2'd2, 16'h00F0);
    instr_op("or_f0f0", 2'b11, 2'd1, 16'hF0F0);
    instr_wb("ldi_r2_ff", 2'd2, 16'h00FF);
    e = 16'h00FF;
    for (int i = 0; i < 4; i++) begin
      e = e << 1;
      instr_wb("dbl_r2", 2'd2, e);
    end
    instr_op("and", 2'b10, 2'd3, 16'h00F0);
    instr_op("or", 2'b11, 2'd3, 16'hFFF0);
    instr_wb("add_rd_eq_rs1", 2'd3, 16'hF0E0);
    jmp_chk("jmp_fe", 8'hFE);
    instr_wb("ldi_fe", 2'd0, 16'd7);
    chk("pc_ff", 32'(imem_addr), 32'hFF);
    instr_wb("ldi_ff", 2'd0, 16'd9);
    chk("pc_wrap", 32'(imem_addr), 32'd0);

    // Program B: HALT persistence.
    do_reset();
    clear_mem();
    mem[0] = f_ldi(2'd1, 8'd3);
    do_start();
    instr_wb("halt_pre", 2'd1, 16'd3);
    tick(); tick(); tick();
    chk("halt.halted", 32'(halted), 32'd1);
    chk("halt.busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("halt_start.halted", 32'(halted), 32'd1);
    chk("halt_start.addr", 32'(imem_addr), 32'd1);

    // Program C: reset during EXEC aborts the write and clears registers.
    do_reset();
    chk("rst_halt.halted", 32'(halted), 32'd0);
    mem[0] = f_ldi(2'd1, 8'd7);
    mem[1] = f_alu(2'b00, 2'd2, 2'd1, 2'd1);
    do_start();
    instr_wb("abort_ldi", 2'd1, 16'd7);
    tick(); tick();
    chk("abort.exec_a", 32'(alu_a), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.wb_valid", 32'(wb_valid), 32'd0);
    tick(); tick();
    chk("abort.idle_wb", 32'(wb_valid) | 32'(busy), 32'd0);
    mem[0] = f_alu(2'b00, 2'd0, 2'd0, 2'd1);
    mem[1] = f_alu(2'b00, 2'd0, 2'd2, 2'd3);
    do_start();
    tick(); tick();
    chk("regs_r0_r1", {alu_a, alu_b}, 32'd0);
    tick(); tick(); tick(); tick();
    chk("regs_r2_r3", {alu_a, alu_b}, 32'd0);

    // Program Z: zero flag and conditional jumps.
    do_reset();
    clear_mem();
    mem[0]     = f_ldi(2'd1, 8'd10);
    mem[1]     = f_alu(2'b01, 2'd0, 2'd1, 2'd1);
    mem[2]     = f_jmp(1'b1, 8'h10);
    mem[8'h10] = f_ldi(2'd2, 8'd5);
    mem[8'h11] = f_alu(2'b01, 2'd0, 2'd1, 2'd2);
    mem[8'h12] = f_jmp(1'b1, 8'h40);
    do_start();
    instr_wb("z_ldi", 2'd1, 16'd10);
    instr_wb("z_sub0", 2'd0, 16'd0);
`ifdef CPU_CTRL_ZERO_FLAG_EN
    chk("z_sub0.zero_flag", 32'(zero_flag), 32'd1);
`else
    chk("z_sub0.zero_flag", 32'(zero_flag), 32'd0);
`endif
    jmp_chk("z_jmp_taken", 8'h10);
    instr_wb("z_ldi_r2", 2'd2, 16'd5);
`ifdef CPU_CTRL_ZERO_FLAG_EN
    chk("z_ldi.zero_flag_kept", 32'(zero_flag), 32'd1);
`else
    chk("z_ldi.zero_flag_kept", 32'(zero_flag), 32'd0);
`endif
    instr_wb("z_sub5", 2'd0, 16'd5);
    chk("z_sub5.zero_flag", 32'(zero_flag), 32'd0);
`ifdef CPU_CTRL_ZERO_FLAG_EN
    jmp_chk("z_jmp_not_taken", 8'h13);
`else
    jmp_chk("z_jmp_uncond", 8'h40);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameter DATA_W, default 16, ALU/register data width.
REQ-002 Parameter PC_W, default 8, program counter / instruction address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin execution from pc=0; sampled only in IDLE.
REQ-006 imem_addr  output  PC_W  instruction address; imem read latency exactly one cycle.
REQ-007 imem_rdata  input  16  instruction word for address presented the previous cycle.
REQ-008 alu_a, alu_b  output  DATA_W  operands to the combinational ALU.
REQ-009 alu_op  output  2  ALU opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-010 alu_result  input  DATA_W  ALU result, valid in the same cycle as its operands.
REQ-011 wb_valid  output  1  one-cycle pulse on register write.
REQ-012 wb_rd, wb_data  output  2 / DATA_W  destination index and written value, valid with wb_valid.
REQ-013 busy  output  1  high in FETCH, DECODE, EXEC and WB.
REQ-014 halted  output  1  high in HALT.
REQ-015 zero_flag  output  1  zero flag (see Configuration).

Function
REQ-016 Instruction bits [15:14]: 00 ALU, 01 LOADI, 10 JMP, 11 HALT.
REQ-017 ALU fields: [13:12] alu_op, [11:10] rd, [9:8] rs1, [7:6] rs2; LOADI: [11:10] rd, [7:0] imm zero-extended; JMP: [13] cond, [7:0] target.
REQ-018 FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-019 IDLE->FETCH on start; otherwise hold IDLE.
REQ-020 FETCH: imem_addr=pc; always ->DECODE.
REQ-021 DECODE: latch imem_rdata into ir; ->EXEC.
REQ-022 EXEC: alu_a=reg[rs1], alu_b=reg[rs2], alu_op=ir[13:12]; latch alu_result (ALU) or imm (LOADI) into result register; ALU/LOADI ->WB, JMP ->FETCH with pc updated, HALT ->HALT.
REQ-023 WB: reg[rd]=result, wb_valid=1, pc=pc+1 (modulo 2^PC_W, 255 wraps to 0), ->FETCH.
REQ-024 Latency: ALU and LOADI 4 cycles; JMP 3 cycles; HALT reached in 3 cycles after FETCH.
REQ-025 Outside EXEC, alu_a, alu_b and alu_op SHALL be 0.
REQ-026 rd equal to rs1 or rs2 SHALL use the pre-write operand values.
REQ-027 start asserted outside IDLE SHALL be ignored.
REQ-028 HALT SHALL persist until rst; start has no effect.
REQ-029 Arithmetic wraps modulo 2^DATA_W; no carry or overflow state.

Reset
REQ-030 rst SHALL force IDLE in any state, including mid-instruction, aborting the instruction without write.
REQ-031 Reset values: pc=0, ir=0, registers r0-r3=0, result=0, zero_flag=0, imem_addr=0, all outputs 0.

Configuration
REQ-032 Macro CPU_CTRL_ZERO_FLAG_EN defined: in WB of ALU instructions only, zero_flag=(result==0); JMP with cond=1 jumps only if zero_flag=1, else pc=pc+1.
REQ-033 Macro undefined: zero_flag tied 0, cond bit ignored, every JMP unconditional.

Structure
REQ-034 Package cpu_pkg SHALL hold the state enum, instruction-class constants, ALU opcode enum and DATA_W/PC_W defaults.
REQ-035 Register file SHALL be a sub-module cpu_regfile: 4x DATA_W, two async read ports, one sync write port, synchronous reset.

Verification
REQ-036 LOADI r1,10; LOADI r2,5; ALU ADD r3,r1,r2 -> wb_valid with wb_rd=3, wb_data=15, exactly 4 cycles after FETCH of ADD.
REQ-037 r1=10, r2=5, SUB r0,r2,r1 -> wb_data=0xFFFB; with CPU_CTRL_ZERO_FLAG_EN, zero_flag=0.
REQ-038 r1=0xF0F0, r2=0x0FF0: AND -> 0x00F0; OR -> 0xFFF0; alu_op equals 10 / 11 only during EXEC.
REQ-039 JMP 0x20 at pc 5 -> next imem_addr=0x20, no wb_valid; pc 255 executing LOADI -> next fetch address 0.
REQ-040 HALT -> halted=1, busy=0; start pulse ignored; rst asserted during EXEC of ADD -> no wb_valid, IDLE, r0-r3 read 0.
REQ-041 With CPU_CTRL_ZERO_FLAG_EN: SUB r0,r1,r1 -> zero_flag=1, conditional JMP taken; SUB with non-zero result -> conditional JMP not taken, pc+1.
